// File: rtl/bcd_display_conv_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_conv_if
// Description : Display-converter bus: accumulator input and digit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_conv_if;
  logic [7:0] value;
  logic       dec_mode;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic       hi_en;
  logic       ovf;
  logic       busy;
  logic       upd;

  // Master drives the value to show; slave is the converter.
  modport master (
    output value,
    output dec_mode,
    input  digit_lo,
    input  digit_hi,
    input  hi_en,
    input  ovf,
    input  busy,
    input  upd
  );

  modport slave (
    input  value,
    input  dec_mode,
    output digit_lo,
    output digit_hi,
    output hi_en,
    output ovf,
    output busy,
    output upd
  );
endinterface
`default_nettype wire

// File: rtl/bcd_display_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_conv
// Description : 8-bit binary to two-digit display converter (hex or decimal),
//               sequential double-dabble, fixed 10-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_conv #(
  parameter int BLANK_LEADING = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  bcd_display_conv_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_sh_val;
  logic       r_sh_mode;
  logic       r_first;
  logic [2:0] r_cnt;

  logic [1:0] r_hund;
  logic [3:0] r_tens;
  logic [3:0] r_ones;

  logic [3:0] r_digit_lo;
  logic [3:0] r_digit_hi;
  logic       r_hi_en;
  logic       r_ovf;
  logic       r_busy;
  logic       r_upd;

  logic       w_capture;
  logic       w_shift;
  logic       w_load;
  logic       w_changed;
  logic [2:0] w_bit_idx;
  logic       w_in_bit;
  logic [3:0] w_ones_adj;
  logic [3:0] w_tens_adj;
  logic       w_dec_hi_en;

  assign w_changed = ({bus.dec_mode, bus.value} != {r_sh_mode, r_sh_val});

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_first || w_changed) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == 3'd7) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Double-dabble step: adjust, then shift in the next shadow bit, MSB first.
  // Hundreds never reaches 5 for an 8-bit input, so it needs no adjust.
  // ------------------------------------------------------------------------
  assign w_bit_idx  = 3'd7 - r_cnt;
  assign w_in_bit   = r_sh_val[w_bit_idx];
  assign w_ones_adj = (r_ones >= 4'd5) ? (r_ones + 4'd3) : r_ones;
  assign w_tens_adj = (r_tens >= 4'd5) ? (r_tens + 4'd3) : r_tens;

  assign w_dec_hi_en = (r_tens != 4'd0) || (r_hund != 2'd0) || (BLANK_LEADING == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_val  <= 8'd0;
      r_sh_mode <= 1'b0;
      r_first   <= 1'b1;
      r_cnt     <= 3'd0;
      r_hund    <= 2'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
    end else if (w_capture) begin
      r_sh_val  <= bus.value;
      r_sh_mode <= bus.dec_mode;
      r_first   <= 1'b0;
      r_cnt     <= 3'd0;
      r_hund    <= 2'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
    end else if (w_shift) begin
      r_hund    <= {r_hund[0], w_tens_adj[3]};
      r_tens    <= {w_tens_adj[2:0], w_ones_adj[3]};
      r_ones    <= {w_ones_adj[2:0], w_in_bit};
      r_cnt     <= r_cnt + 3'd1;
    end
  end

  // ------------------------------------------------------------------------
  // Registered display outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit_lo <= 4'd0;
      r_digit_hi <= 4'd0;
      r_hi_en    <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_upd      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_upd  <= w_load;
      if (w_load) begin
        if (r_sh_mode) begin
          r_digit_lo <= r_ones;
          r_digit_hi <= r_tens;
          r_hi_en    <= w_dec_hi_en;
          r_ovf      <= (r_hund != 2'd0);
        end else begin
          r_digit_lo <= r_sh_val[3:0];
          r_digit_hi <= r_sh_val[7:4];
          r_hi_en    <= 1'b1;
          r_ovf      <= 1'b0;
        end
      end
    end
  end

  assign bus.digit_lo = r_digit_lo;
  assign bus.digit_hi = r_digit_hi;
  assign bus.hi_en    = r_hi_en;
  assign bus.ovf      = r_ovf;
  assign bus.busy     = r_busy;
  assign bus.upd      = r_upd;

endmodule
`default_nettype wire

// File: doc/bcd_display_conv.md
BCD_DISPLAY_CONV -- requirements
Module: bcd_display_conv

Interface
REQ-001 SHALL have parameter: BLANK_LEADING, 1, when 1 in decimal mode tens digit is blanked (hi_en=0) if tens and hundreds are both zero.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: value  input  8  binary accumulator value to display (calculator register A).
REQ-005 SHALL have port: dec_mode  input  1  1 = decimal display, 0 = hexadecimal display.
REQ-006 SHALL have port: digit_lo  output  4  low display digit code (ones / low nibble), feeds segment decoder.
REQ-007 SHALL have port: digit_hi  output  4  high display digit code (tens / high nibble), feeds segment decoder.
REQ-008 SHALL have port: hi_en  output  1  high digit enable; 0 = blank high display.
REQ-009 SHALL have port: ovf  output  1  decimal hundreds nonzero (value >= 100); drives decimal point.
REQ-010 SHALL have port: busy  output  1  conversion in progress (state != IDLE).
REQ-011 SHALL have port: upd  output  1  one-cycle pulse, outputs just updated.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, LOAD; all outputs registered.
REQ-013 IDLE: SHALL capture {dec_mode, value} into shadow register and enter SHIFT when it differs from last captured pair or when first-conversion flag set; else stay IDLE.
REQ-014 SHIFT: SHALL run 8 double-dabble iterations, one per cycle, on 3 BCD nibbles (hundreds 2 bits sufficient, ones, tens): per iteration add 3 to any nibble >= 5, then shift left taking next shadow MSB; 3-bit iteration counter.
REQ-015 SHIFT SHALL exit to LOAD after 8th iteration; LOAD SHALL write outputs and return to IDLE.
REQ-016 Latency SHALL be fixed: capture edge E0, shifts on E1..E8, outputs written on E9; upd high for exactly the cycle following E9; mode-independent.
REQ-017 busy SHALL be high from after E0 through E9 inclusive-edge, low in IDLE.
REQ-018 Hex mode: digit_lo=value[3:0], digit_hi=value[7:4], hi_en=1, ovf=0 (from shadow).
REQ-019 Decimal mode: digit_lo=ones, digit_hi=tens, ovf=(hundreds!=0), hi_en=(tens!=0 or hundreds!=0 or BLANK_LEADING==0).
REQ-020 value/dec_mode changes while busy SHALL be ignored for the running conversion; on return to IDLE comparison against shadow SHALL trigger a new conversion, so final input is always displayed.
REQ-021 Unchanged input SHALL cause no conversion, no upd, outputs held.
REQ-022 Boundaries: 99 -> 9/9 ovf=0; 100 -> 0/0 ovf=1 hi_en=1; 255 -> 5/5 ovf=1; 0 -> 0/0 ovf=0.
REQ-023 Mode toggle with same value SHALL trigger reconversion.

Reset
REQ-024 rst SHALL force: state IDLE, digit_lo=0, digit_hi=0, hi_en=0, ovf=0, busy=0, upd=0, counter=0, shadow=0, first-conversion flag=1.
REQ-025 rst mid-conversion SHALL abort with no upd pulse; rst dominates all other events in same cycle.
REQ-026 First IDLE cycle after rst deasserts SHALL start a conversion regardless of input value.

Verification
REQ-027 rst, release with value=0, dec_mode=1 -> upd 10 cycles later, digit_lo=0, hi_en=0, ovf=0, busy high 9 cycles.
REQ-028 value 0 -> 42 decimal -> digit_hi=4, digit_lo=2, hi_en=1, ovf=0, upd exactly at cycle E9+1; value 7 -> hi_en=0.
REQ-029 value=255 decimal -> 5/5 ovf=1; toggle dec_mode=0 -> F/F hi_en=1 ovf=0 after one more conversion.
REQ-030 value 12, change to 34 at 4th busy cycle -> upd showing 1/2, then second upd showing 3/4, exactly two pulses.
REQ-031 rst asserted during 5th SHIFT cycle -> next cycle all outputs 0, busy=0, no upd; conversion restarts after release.
REQ-032 value 99 then 100 decimal -> 9/9 ovf=0, then 0/0 ovf=1 hi_en=1; holding 100 -> no further upd.
